// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// slave = arbiter side, master = requesters/consumer/ALU side.
interface alu_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic              req0_valid;
   logic [OP_W-1:0]   req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req0_ready;

   logic              req1_valid;
   logic [OP_W-1:0]   req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              req1_ready;

   logic              rsp_valid;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_zero;
   logic              rsp_ready;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_ctrl;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   logic              busy;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready, alu_result, alu_zero,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_zero,
      output alu_a, alu_b, alu_ctrl, busy
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready, alu_result, alu_zero,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_zero,
      input  alu_a, alu_b, alu_ctrl, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU: IDLE -> EXEC -> RESP, one op per 3 cycles.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]        state;
   logic              grant;
   logic              accept;
   logic [OP_W-1:0]   cap_op;
   logic [DATA_W-1:0] cap_a;
   logic [DATA_W-1:0] cap_b;
   logic              cap_id;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_zero_q;
   logic              rsp_id_q;

   // Undefined codes fall back to ADD so the ALU only ever sees a supported operation.
   function automatic logic [OP_W-1:0] legal_op(input logic [OP_W-1:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
         4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1111: legal_op = op;
         default:                                              legal_op = '0;
      endcase
   endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb grant = ~bus.req0_valid;
`else
   logic last;

   always_comb begin
      // NOTE: assign a default before any branch so no path leaves grant unassigned (no latch).
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) grant = ~last;
      else if (bus.req1_valid)              grant = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last <= 1'b1;
      else if (accept) last <= grant;
   end
`endif

   // Ready is gated by rst_n so it reads 0 while reset is held, even with valid requests.
   assign accept         = rst_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
   assign bus.req0_ready = accept && !grant;
   assign bus.req1_ready = accept && grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state      <= IDLE;
         cap_op     <= '0;
         cap_a      <= '0;
         cap_b      <= '0;
         cap_id     <= 1'b0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
         rsp_id_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cap_id <= grant;
                  cap_op <= legal_op(grant ? bus.req1_op : bus.req0_op);
                  cap_a  <= grant ? bus.req1_a : bus.req0_a;
                  cap_b  <= grant ? bus.req1_b : bus.req0_b;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_data_q <= bus.alu_result;
               rsp_zero_q <= bus.alu_zero;
               rsp_id_q   <= cap_id;
               state      <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.busy      = (state != IDLE);

   // The shared ALU sees an ADD of zeros whenever this block is not executing.
   assign bus.alu_a    = (state == EXEC) ? cap_a  : '0;
   assign bus.alu_b    = (state == EXEC) ? cap_b  : '0;
   assign bus.alu_ctrl = (state == EXEC) ? cap_op : '0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, contention, backpressure, mid-op reset, random traffic.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   tb_last = 1'b1;
   logic [15:0] legal_mask = 16'b1011_1101_1111_0011;

   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

   alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (c)
         4'b0001: r = a - b;
         4'b0100: r = a & b;
         4'b0101: r = a | b;
         4'b0110: r = a ^ b;
         4'b0111: r = ~(a | b);
         4'b1000: r = {31'b0, $signed(a) < $signed(b)};
         4'b1010: r = a << b[4:0];
         4'b1011: r = $signed(a) >>> b[4:0];
         4'b1100: r = a >> b[4:0];
         4'b1101: r = {31'b0, a < b};
         4'b1111: r = b;
         default: r = a + b;
      endcase
      return r;
   endfunction

   // Shared ALU model driven by the arbiter's ALU outputs.
   always_comb begin
      bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
      bus.alu_zero   = (bus.alu_result == 32'd0);
   end

   function automatic logic [3:0] eff_op(input logic [3:0] op);
      return legal_mask[op] ? op : 4'b0000;
   endfunction

   // Arbitration rule: lone valid wins; contention goes to whoever was not granted last.
   function automatic bit pick(input bit v0, input bit v1);
      bit g;
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = !v0;
`else
      g = (v0 && v1) ? !tb_last : v1;
`endif
      tb_last = g;
      return g;
   endfunction

   task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b0;
      tb_last = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One transaction starting in IDLE, #1 after a rising edge; ends the same way back in IDLE.
   task automatic txn(input bit v0, input bit v1,
                      input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                      input int hold, input bit eid, input logic [3:0] ectrl,
                      input logic [31:0] edata, input bit ezero);
      logic [31:0] ea, eb;
      ea = eid ? a1 : a0;
      eb = eid ? b1 : b0;
      bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
      bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
      bus.rsp_ready  = (hold == 0);
      #1;
      check_b("accept_ready0", bus.req0_ready, !eid);
      check_b("accept_ready1", bus.req1_ready, eid);
      check_w("idle_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_a = $urandom;
      bus.req1_b = $urandom;
      check_b("exec_busy", bus.busy, 1'b1);
      check_b("exec_rsp_valid", bus.rsp_valid, 1'b0);
      check_w("exec_alu_ctrl", 32'(bus.alu_ctrl), 32'(ectrl));
      check_w("exec_alu_a", bus.alu_a, ea);
      check_w("exec_alu_b", bus.alu_b, eb);
      @(posedge clk); #1;
      check_b("rsp_valid", bus.rsp_valid, 1'b1);
      check_b("rsp_id", bus.rsp_id, eid);
      check_w("rsp_data", bus.rsp_data, edata);
      check_b("rsp_zero", bus.rsp_zero, ezero);
      check_w("resp_alu_a", bus.alu_a, 32'd0);
      if (hold > 0) begin
         bus.req0_valid = 1'b1;
         bus.req1_valid = 1'b1;
         for (int k = 0; k < hold; k++) begin
            bus.req0_op = 4'($urandom);
            bus.req1_a  = $urandom;
            #1;
            check_b("hold_rsp_valid", bus.rsp_valid, 1'b1);
            check_w("hold_rsp_data", bus.rsp_data, edata);
            check_b("hold_rsp_zero", bus.rsp_zero, ezero);
            check_b("hold_rsp_id", bus.rsp_id, eid);
            check_b("hold_no_ready", bus.req0_ready | bus.req1_ready, 1'b0);
            if (k < hold - 1) begin
               @(posedge clk); #1;
            end
         end
         bus.rsp_ready = 1'b1;
         #1;
         check_b("retire_no_ready", bus.req0_ready | bus.req1_ready, 1'b0);
         @(posedge clk); #1;
         check_b("ready_after_retire", bus.req0_ready | bus.req1_ready, 1'b1);
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
         bus.rsp_ready  = 1'b0;
      end else begin
         @(posedge clk); #1;
      end
      check_b("done_rsp_valid", bus.rsp_valid, 1'b0);
      check_b("done_busy", bus.busy, 1'b0);
   endtask

   typedef struct {
      bit          id;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          hold;
      logic [3:0]  ctrl;
      logic [31:0] data;
      bit          zero;
   } vec_t;

   initial begin
      vec_t vecs[6];
      bit   g;

      vecs[0] = '{1'b0, 4'b0000, 32'd5,          32'd7,          0, 4'b0000, 32'd12,         1'b0};
      vecs[1] = '{1'b1, 4'b0001, 32'h0000_1234,  32'h0000_1234,  4, 4'b0001, 32'd0,          1'b1};
      vecs[2] = '{1'b0, 4'b1011, 32'h8000_0000,  32'd4,          0, 4'b1011, 32'hF800_0000,  1'b0};
      vecs[3] = '{1'b0, 4'b0010, 32'd3,          32'd4,          0, 4'b0000, 32'd7,          1'b0};
      vecs[4] = '{1'b0, 4'b0100, 32'h0000_F0F0,  32'h0000_0FF0,  1, 4'b0100, 32'h0000_00F0,  1'b0};
      vecs[5] = '{1'b1, 4'b1110, 32'd1,          32'd2,          0, 4'b0000, 32'd3,          1'b0};

      bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp_ready  = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #2;
      check_b("reset_ready0", bus.req0_ready, 1'b0);
      check_b("reset_ready1", bus.req1_ready, 1'b0);
      check_b("reset_rsp_valid", bus.rsp_valid, 1'b0);
      check_b("reset_busy", bus.busy, 1'b0);
      check_w("reset_rsp_data", bus.rsp_data, 32'd0);
      check_w("reset_alu_b", bus.alu_b, 32'd0);
      do_reset();

      // Directed single-requester vectors.
      for (int i = 0; i < 6; i++) begin
         g = pick(!vecs[i].id, vecs[i].id);
         txn(!vecs[i].id, vecs[i].id,
             vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hold, vecs[i].id, vecs[i].ctrl, vecs[i].data, vecs[i].zero);
      end

      // Both requesters valid every cycle after reset.
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_op = 4'b0000; bus.req0_a = 32'd10; bus.req0_b = 32'd20;
      bus.req1_valid = 1'b1; bus.req1_op = 4'b0001; bus.req1_a = 32'd50; bus.req1_b = 32'd8;
      bus.rsp_ready  = 1'b1;
      for (int t = 0; t < 4; t++) begin
         g = pick(1'b1, 1'b1);
         #1;
         check_b("rr_ready0", bus.req0_ready, !g);
         check_b("rr_ready1", bus.req1_ready, g);
         @(posedge clk); #1;
         check_b("rr_exec_no_ready", bus.req0_ready | bus.req1_ready, 1'b0);
         @(posedge clk); #1;
         check_b("rr_rsp_id", bus.rsp_id, g);
         check_w("rr_rsp_data", bus.rsp_data, g ? alu_fn(4'b0001, 32'd50, 32'd8) : alu_fn(4'b0000, 32'd10, 32'd20));
         check_b("rr_resp_no_ready", bus.req0_ready | bus.req1_ready, 1'b0);
         @(posedge clk);
      end
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      // Random traffic against the reference rules.
      do_reset();
      for (int n = 0; n < 40; n++) begin
         int          pat;
         bit          v0, v1;
         logic [3:0]  op0, op1, c;
         logic [31:0] a0, b0, a1, b1, d;
         pat = $urandom_range(0, 2);
         v0  = (pat != 1);
         v1  = (pat != 0);
         op0 = 4'($urandom); op1 = 4'($urandom);
         a0  = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
         a1  = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
         g   = pick(v0, v1);
         c   = eff_op(g ? op1 : op0);
         d   = alu_fn(c, g ? a1 : a0, g ? b1 : b0);
         txn(v0, v1, op0, a0, b0, op1, a1, b1, $urandom_range(0, 2), g, c, d, d == 32'd0);
      end

      // Reset asserted while an operation is executing.
      bus.req1_valid = 1'b1; bus.req1_op = 4'b0000; bus.req1_a = 32'd9; bus.req1_b = 32'd1;
      bus.rsp_ready  = 1'b1;
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      check_b("midrst_exec_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      tb_last = 1'b1;
      #1;
      check_b("midrst_busy", bus.busy, 1'b0);
      check_b("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      check_w("midrst_rsp_data", bus.rsp_data, 32'd0);
      check_w("midrst_alu_a", bus.alu_a, 32'd0);
      check_w("midrst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check_b("postrst_no_rsp", bus.rsp_valid, 1'b0);
      end
      g = pick(1'b1, 1'b1);
      txn(1'b1, 1'b1, 4'b0101, 32'h0F, 32'hF0, 4'b0000, 32'd1, 32'd1,
          0, g, g ? 4'b0000 : 4'b0101, g ? 32'd2 : 32'hFF, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
